// File: rtl/score_bcd_encoder_pkg.sv
// Shared constants and state encoding for the score display blocks.
// MAX_VAL is the largest value an NDIG-digit decimal display can show.
package score_bcd_encoder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } conv_state_t;

   localparam int DEFAULT_NDIG = 4;

   // Largest decimal value representable in ndig digits (10^ndig - 1).
   function automatic int max_val(input int ndig);
      int p;
      p = 1;
      for (int i = 0; i < ndig; i++) begin
         p = p * 10;
      end
      return p - 1;
   endfunction

   localparam int MAX_VAL = max_val(DEFAULT_NDIG);

endpackage

// File: rtl/score_bcd_encoder_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_add3 (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/score_bcd_encoder.sv
// Sequential binary-to-BCD converter for the score display (double-dabble,
// one bit per clock), with saturation to all nines and leading-zero blanking.
module score_bcd_encoder
   import score_bcd_encoder_pkg::*;
#(
   parameter int BIN_W = 14,
   parameter int NDIG  = 4
) (
   input  logic                clkin,
   input  logic                reset,
   input  logic                start,
   input  logic [BIN_W-1:0]    bin,
   output logic                busy,
   output logic                done,
   output logic [4*NDIG-1:0]   digits,
   output logic                overflow,
   output logic [NDIG-1:0]     blank
);

   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int CMP_W = (BIN_W > 32) ? BIN_W : 32;
   localparam logic [CMP_W-1:0] MAX_CMP = CMP_W'(max_val(NDIG));

   conv_state_t           state, next_state;
   logic [BIN_W-1:0]      shreg;
   logic [BIN_W-1:0]      bin_reg;
   logic [4*NDIG-1:0]     scratch;
   logic [4*NDIG-1:0]     scratch_adj;
   logic [CNT_W-1:0]      iter_cnt;
   logic                  bin_too_big;
   logic                  upper_zero;

   for (genvar g = 0; g < NDIG; g++) begin : g_add3
      bcd_add3 u_add3 (
         .din  (scratch[4*g +: 4]),
         .dout (scratch_adj[4*g +: 4])
      );
   end

   assign busy        = (state != IDLE);
   assign bin_too_big = (CMP_W'(bin_reg) > MAX_CMP);

   always_ff @(posedge clkin) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = SHIFT;
         SHIFT:   if (iter_cnt == CNT_W'(1)) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Results are committed on the edge that leaves DONE, so done and the
   // new digits appear together and then hold until the next conversion.
   always_ff @(posedge clkin) begin
      if (reset) begin
         shreg    <= '0;
         bin_reg  <= '0;
         scratch  <= '0;
         iter_cnt <= '0;
         done     <= 1'b0;
         digits   <= '0;
         overflow <= 1'b0;
      end else begin
         done <= (state == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  shreg    <= bin;
                  bin_reg  <= bin;
                  scratch  <= '0;
                  iter_cnt <= CNT_W'(BIN_W);
               end
            end
            SHIFT: begin
               {scratch, shreg} <= {scratch_adj, shreg} << 1;
               iter_cnt         <= iter_cnt - CNT_W'(1);
            end
            DONE: begin
               overflow <= bin_too_big;
               digits   <= bin_too_big ? {NDIG{4'h9}} : scratch;
            end
            default: ;
         endcase
      end
   end

   // Walk down from the most significant digit; a digit blanks only while
   // everything above it is zero. Digit 0 always shows.
   always_comb begin
      blank      = '0;
      upper_zero = 1'b1;
      for (int i = NDIG - 1; i >= 1; i--) begin
         upper_zero = upper_zero & (digits[4*i +: 4] == 4'd0);
         blank[i]   = upper_zero;
      end
   end

endmodule
